// File: rtl/dualmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dualmem_pkg
// Description : Shared types and helpers for the dual-port byte-lane memory.
//               Holds the init/ready state encoding and the per-lane write
//               arbitration helper used when both ports hit the same word.
// Revision    : 1.0 - initial release
// ============================================================================
package dualmem_pkg;

    // Array life cycle: zero-fill sweep, then normal two-port operation.
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Effective port-B write enable for one byte lane. Port A owns any lane
    // that both ports write to the same word, so B is masked off there.
    function automatic logic lane_b_we(
        input logic a_we,
        input logic b_we,
        input logic same_addr
    );
        return b_we & ~(a_we & same_addr);
    endfunction

endpackage : dualmem_pkg
`default_nettype wire

// File: rtl/dualmem_lane.sv
`default_nettype none
// ============================================================================
// Module      : dualmem_lane
// Description : One 8-bit byte lane, DEPTH entries, two write ports and two
//               asynchronous read ports (read address = write address of the
//               same port). Write arbitration is resolved by the parent; if
//               both enables hit the same entry, port A's write lands last.
// Ports       : clk                       - clock
//               a_we_i/a_addr_i/a_wdata_i - port A write enable/address/data
//               b_we_i/b_addr_i/b_wdata_i - port B write enable/address/data
//               a_rdata_o/b_rdata_o       - current contents at each address
// Revision    : 1.0 - initial release
// ============================================================================
module dualmem_lane #(
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [7:0]    a_wdata_i,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [7:0]    b_wdata_i,
    output logic [7:0]    a_rdata_o,
    output logic [7:0]    b_rdata_o
);

    // Storage is intentionally not reset: contents survive rst.
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
    end

    assign a_rdata_o = mem_q[a_addr_i];
    assign b_rdata_o = mem_q[b_addr_i];

endmodule : dualmem_lane
`default_nettype wire

// File: rtl/dualmem_param.sv
`default_nettype none
// ============================================================================
// Module      : dualmem_param
// Description : Parameterised true dual-port RAM with per-byte write enables,
//               optional zero-fill after reset, write-first cross-port
//               forwarding, port-A priority on same-word write overlap, a
//               collision flag, and an optional output register.
// Ports       : clk, rst                  - clock, sync active-high reset
//               a_en_i/b_en_i             - access request
//               a_we_i/b_we_i             - per-byte write enable (0 = read)
//               a_addr_i/b_addr_i         - word address
//               a_wdata_i/b_wdata_i       - write data
//               a_rdata_o/b_rdata_o       - read data (held between reads)
//               a_rvalid_o/b_rvalid_o     - one pulse per accepted read
//               init_done_o               - array usable
//               coll_o                    - same-word write/write byte overlap
// Revision    : 1.0 - initial release
// ============================================================================
module dualmem_param
    import dualmem_pkg::*;
#(
    parameter  int DATA_W    = 64,   // multiple of 8, >= 8
    parameter  int DEPTH     = 512,  // power of two, >= 2
    parameter  int OUT_REG   = 0,    // 1 adds an output register stage
    parameter  int INIT_ZERO = 1,    // 1 zero-fills the array after reset
    localparam int NB        = DATA_W / 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en_i,
    input  logic [NB-1:0]     a_we_i,
    input  logic [AW-1:0]     a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    input  logic              b_en_i,
    input  logic [NB-1:0]     b_we_i,
    input  logic [AW-1:0]     b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic [DATA_W-1:0] a_rdata_o,
    output logic              a_rvalid_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              b_rvalid_o,
    output logic              init_done_o,
    output logic              coll_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q;
    logic [AW-1:0]       cnt_q;

    logic                a_v1_q;
    logic                b_v1_q;
    logic [DATA_W-1:0]   a_d1_q;
    logic [DATA_W-1:0]   b_d1_q;
    logic                coll_q;

    // ------------------------------------------------------------------
    // Access qualification
    // ------------------------------------------------------------------
    logic                w_ready;
    logic                w_init_wr;
    logic                w_a_acc;
    logic                w_b_acc;
    logic                w_a_rd;
    logic                w_b_rd;
    logic                w_same;
    logic [AW-1:0]       w_a_addr;
    logic [DATA_W-1:0]   w_a_fwd;
    logic [DATA_W-1:0]   w_b_fwd;

    assign w_ready   = (state_q == ST_READY);
    // Requests in the reset cycle are dropped so nothing survives reset.
    assign w_init_wr = (state_q == ST_INIT) & ~rst;
    assign w_a_acc   = a_en_i & w_ready & ~rst;
    assign w_b_acc   = b_en_i & w_ready & ~rst;
    assign w_a_rd    = w_a_acc & ~(|a_we_i);
    assign w_b_rd    = w_b_acc & ~(|b_we_i);
    assign w_same    = (a_addr_i == b_addr_i);

    // The zero-fill sweep borrows port A's write path.
    assign w_a_addr  = w_init_wr ? cnt_q : a_addr_i;

    // ------------------------------------------------------------------
    // Byte lanes with same-cycle write-first forwarding
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic       w_la_we;
        logic       w_lb_we;
        logic       w_a_lane_wr;
        logic       w_b_lane_wr;
        logic [7:0] w_la_wdata;
        logic [7:0] w_ma;
        logic [7:0] w_mb;

        assign w_a_lane_wr = w_a_acc & a_we_i[i];
        assign w_b_lane_wr = w_b_acc & b_we_i[i];
        assign w_la_we     = w_init_wr | w_a_lane_wr;
        assign w_la_wdata  = w_init_wr ? 8'h00 : a_wdata_i[8*i +: 8];
        assign w_lb_we     = lane_b_we(w_a_lane_wr, w_b_lane_wr, w_same);

        dualmem_lane #(
            .DEPTH (DEPTH)
        ) u_lane (
            .clk       (clk),
            .a_we_i    (w_la_we),
            .a_addr_i  (w_a_addr),
            .a_wdata_i (w_la_wdata),
            .b_we_i    (w_lb_we),
            .b_addr_i  (b_addr_i),
            .b_wdata_i (b_wdata_i[8*i +: 8]),
            .a_rdata_o (w_ma),
            .b_rdata_o (w_mb)
        );

        // A reading port sees the other port's same-cycle lane write.
        assign w_a_fwd[8*i +: 8] = (w_b_lane_wr & w_same) ? b_wdata_i[8*i +: 8] : w_ma;
        assign w_b_fwd[8*i +: 8] = (w_a_lane_wr & w_same) ? a_wdata_i[8*i +: 8] : w_mb;
    end

    // ------------------------------------------------------------------
    // Init / ready FSM with zero-fill address counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_READY;
                    end
                end
                default: begin
                    state_q <= ST_READY;
                end
            endcase
        end
    end

    assign init_done_o = w_ready;

    // ------------------------------------------------------------------
    // First read stage and collision flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_v1_q <= 1'b0;
            b_v1_q <= 1'b0;
            a_d1_q <= '0;
            b_d1_q <= '0;
            coll_q <= 1'b0;
        end else begin
            a_v1_q <= w_a_rd;
            b_v1_q <= w_b_rd;
            // Data only moves on an accepted read so it holds otherwise.
            if (w_a_rd) begin
                a_d1_q <= w_a_fwd;
            end
            if (w_b_rd) begin
                b_d1_q <= w_b_fwd;
            end
            coll_q <= w_a_acc & w_b_acc & w_same & (|(a_we_i & b_we_i));
        end
    end

    assign coll_o = coll_q;

    // ------------------------------------------------------------------
    // Optional output register
    // ------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_outreg
        logic              a_v2_q;
        logic              b_v2_q;
        logic [DATA_W-1:0] a_d2_q;
        logic [DATA_W-1:0] b_d2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                a_v2_q <= 1'b0;
                b_v2_q <= 1'b0;
                a_d2_q <= '0;
                b_d2_q <= '0;
            end else begin
                a_v2_q <= a_v1_q;
                b_v2_q <= b_v1_q;
                if (a_v1_q) begin
                    a_d2_q <= a_d1_q;
                end
                if (b_v1_q) begin
                    b_d2_q <= b_d1_q;
                end
            end
        end

        assign a_rvalid_o = a_v2_q;
        assign b_rvalid_o = b_v2_q;
        assign a_rdata_o  = a_d2_q;
        assign b_rdata_o  = b_d2_q;
    end else begin : g_direct
        assign a_rvalid_o = a_v1_q;
        assign b_rvalid_o = b_v1_q;
        assign a_rdata_o  = a_d1_q;
        assign b_rdata_o  = b_d1_q;
    end

endmodule : dualmem_param
`default_nettype wire

// File: doc/dualmem_param.md
DUALMEM_PARAM -- requirements
Module: dualmem_param

Interface
REQ-001 Parameter DATA_W, default 64: data width per port in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DEPTH, default 512: number of words; SHALL be a power of two and at least 2.
REQ-003 Parameter OUT_REG, default 0: 0 gives 1-cycle read latency, 1 adds an output register for 2-cycle read latency.
REQ-004 Parameter INIT_ZERO, default 1: 1 zero-fills the array after reset, 0 skips zero-fill.
REQ-005 Derived constants: NB = DATA_W/8 (byte lanes), AW = $clog2(DEPTH).
REQ-006 clk  in  1  single clock for both ports.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 a_en / b_en  in  1  port access request.
REQ-009 a_we / b_we  in  NB  per-byte write enable; all-zero means read.
REQ-010 a_addr / b_addr  in  AW  word address.
REQ-011 a_wdata / b_wdata  in  DATA_W  write data.
REQ-012 a_rdata / b_rdata  out  DATA_W  read data.
REQ-013 a_rvalid / b_rvalid  out  1  read data valid, one-cycle pulse per accepted read.
REQ-014 init_done  out  1  high when the array is usable.
REQ-015 coll  out  1  one-cycle pulse flagging a same-address write/write byte overlap.

Function
REQ-016 FSM states are INIT and READY.
- Reset enters INIT when INIT_ZERO=1, otherwise READY.
- INIT writes zero to addresses 0..DEPTH-1, one per cycle, through an internal counter.
- INIT moves to READY in the cycle after writing DEPTH-1.
- init_done = (state == READY).
REQ-017 In INIT, a_en and b_en SHALL be ignored: no write, no rvalid, no coll.
REQ-018 Accepted access: x_en=1 while READY.
REQ-019 Write: for each lane i with x_we[i]=1, byte i of the addressed word SHALL take x_wdata byte i at the clock edge.
REQ-020 Read latency: accepted read (x_we=0) SHALL give x_rvalid=1 with data exactly 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
REQ-021 Accepted writes SHALL NOT produce rvalid.
REQ-022 Back-to-back reads on one port SHALL sustain one result per cycle, in order.
REQ-023 x_rdata SHALL hold its last value while x_rvalid=0.
REQ-024 Read of an address written by the other port in the same cycle SHALL return write-first data: written lanes new, other lanes old.
REQ-025 Both ports writing the same address in the same cycle:
- port A wins on each overlapping lane;
- non-overlapping lanes take their own port's data;
- coll SHALL pulse 1 cycle later iff (a_we & b_we) != 0.
REQ-026 Both ports reading the same address SHALL both return the same stored word.
REQ-027 Addresses SHALL use full AW bits with no wrap logic; every address is valid since DEPTH = 2^AW.

Reset
REQ-028 rst SHALL be sampled only on rising clk edges.
REQ-029 Reset SHALL set:
- a_rdata and b_rdata to 0;
- a_rvalid, b_rvalid and coll to 0;
- init_done to 0 when INIT_ZERO=1, else 1;
- the init counter to 0.
REQ-030 Reset SHALL also discard any in-flight read: no rvalid for requests made in or before the reset cycle.
REQ-031 Reset asserted during INIT SHALL restart zero-fill at address 0.
REQ-032 With INIT_ZERO=0, array contents SHALL be unaffected by reset.

Structure
REQ-033 Package dualmem_pkg SHALL hold the FSM state enum (INIT, READY) and a helper function for the per-lane merge mask.
REQ-034 Sub-module dualmem_lane SHALL implement one 8-bit, DEPTH-entry, two-write-port byte lane, with lanes instantiated NB times in a generate loop.
REQ-035 Priority, forwarding, output register and FSM SHALL live in dualmem_param.

Verification
REQ-036 Init: DATA_W=64, DEPTH=512, INIT_ZERO=1, reset 1 cycle -> init_done rises exactly 512 cycles after reset deasserts; a read of address 511 then returns 0.
REQ-037 Byte write: A writes addr 5, we=8'h0F, data 64'h1122334455667788 onto zeros; B reads addr 5 next cycle -> b_rdata = 64'h0000000055667788, b_rvalid 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
REQ-038 Write/write collision: A writes addr 9, we=8'h03, data all 0xAA; B writes addr 9, we=8'h06, data all 0xBB, same cycle -> coll pulses next cycle; a read returns 64'h0000000000BBAAAA.
REQ-039 Cross-port forward: A writes addr 3, we=8'hFF, data 64'hDEADBEEF00000001 while B reads addr 3 -> b_rdata = 64'hDEADBEEF00000001.
REQ-040 Mid-init reset: assert rst at init counter 200 -> init_done stays 0 for a further 512 cycles; a_en pulses during INIT produce no rvalid.
REQ-041 Streaming: 16 consecutive A reads of addresses 0..15 after writing data=address -> 16 contiguous rvalid cycles with data 0..15 in order, for both OUT_REG settings.
